// File: rtl/ov_frame_capture.sv
// OV2640 DVP capture: registers the camera bus, pairs bytes into RGB565 pixels and
// writes complete, clipped frames into a FRAME_W x FRAME_H linear framebuffer.
module ov_frame_capture #(
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240,
  parameter int SKIP_FRAMES = 2,
  parameter int VSYNC_POL   = 1
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        capture_en,
  output logic        fb_wr_en,
  output logic [16:0] fb_wr_addr,
  output logic [15:0] fb_wr_data,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        geom_err
);
  localparam int XW  = $clog2(FRAME_W + 2);
  localparam int YW  = $clog2(FRAME_H + 2);
  localparam int SKW = (SKIP_FRAMES < 1) ? 1 : $clog2(SKIP_FRAMES + 1);

  localparam logic [XW-1:0]  X_END   = XW'(FRAME_W);
  localparam logic [XW-1:0]  X_SAT   = XW'(FRAME_W + 1);
  localparam logic [YW-1:0]  Y_END   = YW'(FRAME_H);
  localparam logic [YW-1:0]  Y_SAT   = YW'(FRAME_H + 1);
  localparam logic [17:0]    LB_STEP = 18'(FRAME_W);
  localparam logic [SKW-1:0] SK_N    = SKW'(SKIP_FRAMES);
  localparam logic           VB_INV  = (VSYNC_POL == 0);

  typedef enum logic [1:0] {SKIP, WAIT, CAPTURE} state_t;

  state_t         state;
  logic           vs_r, href_r, vb_q, href_q, phase;
  logic [7:0]     d_r, hi;
  logic [1:0]     arm;
  logic [SKW-1:0] skip_cnt;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [17:0]    line_base;

  logic          vb, frame_start, frame_end, line_start, line_end;
  logic          in_cap, eff_phase, do_byte, do_pix, do_lend, pix_in_win;
  logic [YW-1:0] y_inc, y_after;

  // Edges are ignored until both the input and history registers hold real samples,
  // so a bus already in blanking at reset release is not seen as a frame end.
  always_comb begin
    vb          = vs_r ^ VB_INV;
    frame_start = arm[1] & vb_q & ~vb;
    frame_end   = arm[1] & ~vb_q & vb;
    line_start  = arm[1] & href_r & ~href_q;
    line_end    = arm[1] & ~href_r & href_q;
    in_cap      = (state == CAPTURE);
    eff_phase   = line_start ? 1'b0 : phase;
    do_byte     = in_cap & href_r & ~frame_end;
    do_pix      = do_byte & eff_phase;
    do_lend     = in_cap & (line_end | (frame_end & href_r));
    pix_in_win  = (x < X_END) && (y < Y_END);
    y_inc       = (y == Y_SAT) ? y : y + YW'(1);
    y_after     = do_lend ? y_inc : y;
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      state       <= SKIP;
      vs_r        <= 1'b0;
      href_r      <= 1'b0;
      d_r         <= '0;
      vb_q        <= 1'b0;
      href_q      <= 1'b0;
      arm         <= '0;
      skip_cnt    <= '0;
      x           <= '0;
      y           <= '0;
      line_base   <= '0;
      phase       <= 1'b0;
      hi          <= '0;
      fb_wr_en    <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      geom_err    <= 1'b0;
    end else begin
      vs_r       <= cam_vsync;
      href_r     <= cam_href;
      d_r        <= cam_data;
      vb_q       <= vb;
      href_q     <= href_r;
      arm        <= {arm[0], 1'b1};
      fb_wr_en   <= 1'b0;
      frame_done <= 1'b0;

      if (do_byte) begin
        phase <= ~eff_phase;
        if (!eff_phase) hi <= d_r;
      end

      if (do_pix) begin
        if (x != X_SAT) x <= x + XW'(1);
        if (pix_in_win) begin
          fb_wr_en   <= 1'b1;
          fb_wr_addr <= 17'(line_base + 18'(x));
          fb_wr_data <= {hi, d_r};
        end
      end

      // A dangling odd byte is simply dropped along with the phase reset.
      if (do_lend) begin
        if (x != X_END || eff_phase) geom_err <= 1'b1;
        x     <= '0;
        y     <= y_inc;
        phase <= 1'b0;
        if (y < Y_END) line_base <= line_base + LB_STEP;
      end

      case (state)
        SKIP: begin
          if (skip_cnt == SK_N) state <= WAIT;
          else if (frame_end)   skip_cnt <= skip_cnt + SKW'(1);
        end
        WAIT: begin
          if (frame_start && capture_en) begin
            state     <= CAPTURE;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            phase     <= 1'b0;
          end
        end
        CAPTURE: begin
          if (frame_end) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            if (y_after != Y_END) geom_err <= 1'b1;
            state <= WAIT;
          end
        end
        default: state <= SKIP;
      endcase
    end
  end
endmodule

// File: tb/tb_ov_frame_capture.sv
// Directed bench for ov_frame_capture with a 4x3 frame, two skipped frames, vsync high in blanking.
module tb_ov_frame_capture;
  logic        clk = 1'b0;
  logic        rst, cam_vsync, cam_href, capture_en;
  logic [7:0]  cam_data;
  logic        fb_wr_en, frame_done, geom_err;
  logic [16:0] fb_wr_addr;
  logic [15:0] fb_wr_data;
  logic [7:0]  frame_count;

  int errs = 0, checks = 0;
  int done_cnt = 0, overlap = 0;
  logic [16:0] ga[$];
  logic [15:0] gd[$];

  ov_frame_capture #(.FRAME_W(4), .FRAME_H(3), .SKIP_FRAMES(2), .VSYNC_POL(1)) dut (
    .cam_pclk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .capture_en(capture_en), .fb_wr_en(fb_wr_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .frame_done(frame_done),
    .frame_count(frame_count), .geom_err(geom_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (fb_wr_en) begin
        ga.push_back(fb_wr_addr);
        gd.push_back(fb_wr_data);
      end
      if (frame_done) done_cnt++;
      if (frame_done && fb_wr_en) overlap++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pixel i of line l carries {tag, 0x1F + 16*l + i}; the first pixel of a 0xF8 frame is 0xF81F.
  task automatic send_line(input logic [7:0] tag, input int l, input int npix, input bit lat);
    logic [15:0] p;
    for (int i = 0; i < npix; i++) begin
      p = {tag, 8'(31 + l * 16 + i)};
      cam_href = 1'b1;
      cam_data = p[15:8];
      tick();
      if (lat && i == 1) begin
        chk("lat_wr_en", 32'(fb_wr_en), 1);
        chk("lat_addr", 32'(fb_wr_addr), 0);
        chk("lat_data", 32'(fb_wr_data), 32'h0000F81F);
      end
      cam_data = p[7:0];
      tick();
      if (lat && i == 0) chk("lat_early", 32'(fb_wr_en), 0);
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    tick(3);
  endtask

  task automatic run_frame(input logic [7:0] tag, input int nlines, input int wide, input int drop,
                           input bit lat, input bit end_err, input int exp_wr, input int exp_done,
                           input string nm);
    int wb, db;
    wb = ga.size();
    db = done_cnt;
    cam_vsync = 1'b0;
    tick(3);
    for (int l = 0; l < nlines; l++) begin
      if (l == drop) capture_en = 1'b0;
      if (l == wide) chk({nm, "_geom_pre_line"}, 32'(geom_err), 0);
      send_line(tag, l, (l == wide) ? 6 : 4, lat && l == 0);
      if (l == wide) chk({nm, "_geom_long_line"}, 32'(geom_err), 1);
    end
    if (end_err) chk({nm, "_geom_pre_end"}, 32'(geom_err), 0);
    cam_vsync = 1'b1;
    tick(5);
    if (end_err) chk({nm, "_geom_tall_frame"}, 32'(geom_err), 1);
    chk({nm, "_writes"}, 32'(ga.size() - wb), 32'(exp_wr));
    chk({nm, "_done"}, 32'(done_cnt - db), 32'(exp_done));
    if (exp_wr == 12 && ga.size() - wb == 12) begin
      for (int k = 0; k < 12; k++) begin
        chk({nm, "_addr"}, 32'(ga[wb + k]), 32'(k));
        chk({nm, "_data"}, 32'(gd[wb + k]), 32'({tag, 8'(31 + (k / 4) * 16 + k % 4)}));
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    cam_data   = 8'h00;
    capture_en = 1'b1;
    tick(2);
    chk("rst_wr_en", 32'(fb_wr_en), 0);
    chk("rst_addr", 32'(fb_wr_addr), 0);
    chk("rst_data", 32'(fb_wr_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_geom", 32'(geom_err), 0);
    rst = 1'b0;
    tick(3);

    // two settling frames, then the first captured frame with latency probe
    run_frame(8'h10, 3, -1, -1, 1'b0, 1'b0, 0, 0, "skip1");
    run_frame(8'h20, 3, -1, -1, 1'b0, 1'b0, 0, 0, "skip2");
    run_frame(8'hF8, 3, -1, -1, 1'b1, 1'b0, 12, 1, "cap1");
    chk("cap1_count", 32'(frame_count), 1);
    chk("cap1_geom", 32'(geom_err), 0);

    // capture_en dropped mid-frame: that frame completes, the next is not captured
    run_frame(8'h40, 3, -1, 1, 1'b0, 1'b0, 12, 1, "drop_cur");
    run_frame(8'h50, 3, -1, -1, 1'b0, 1'b0, 0, 0, "drop_next");
    capture_en = 1'b1;
    tick(2);
    run_frame(8'h60, 3, -1, -1, 1'b0, 1'b0, 12, 1, "resume");
    chk("resume_count", 32'(frame_count), 3);

    // six-pixel line 1 is clipped to four and flags geometry
    run_frame(8'h70, 3, 1, -1, 1'b0, 1'b0, 12, 1, "wide");
    chk("wide_count", 32'(frame_count), 4);

    // reset in the middle of a line of a captured frame
    cam_vsync = 1'b0;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      cam_href = 1'b1;
      cam_data = 8'h80;
      tick();
      cam_data = 8'(31 + i);
      tick();
    end
    cam_data = 8'h80;
    tick();
    chk("pre_rst_wr_en", 32'(fb_wr_en), 1);
    chk("pre_rst_addr", 32'(fb_wr_addr), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(fb_wr_en), 0);
    chk("mid_rst_addr", 32'(fb_wr_addr), 0);
    chk("mid_rst_data", 32'(fb_wr_data), 0);
    chk("mid_rst_count", 32'(frame_count), 0);
    chk("mid_rst_geom", 32'(geom_err), 0);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(3);
    run_frame(8'hA0, 3, -1, -1, 1'b0, 1'b0, 0, 0, "reskip1");
    run_frame(8'hB0, 3, -1, -1, 1'b0, 1'b0, 0, 0, "reskip2");

    // five-line frame: rows 3..4 are clipped, frame end flags geometry
    run_frame(8'hC0, 5, -1, -1, 1'b0, 1'b1, 12, 1, "tall");
    chk("tall_count", 32'(frame_count), 1);
    chk("done_write_overlap", 32'(overlap), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
